// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the multi-key cipher controller: FSM states,
// register word indices, CTRL bit positions and register-lock bit positions.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_BUSY = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Register word indices (byte address >> 3).
    localparam int unsigned IDX_CTRL    = 0;
    localparam int unsigned IDX_STATUS  = 1;
    localparam int unsigned IDX_KEY_SEL = 2;
    localparam int unsigned IDX_DATA_IN = 4;
    localparam int unsigned IDX_KEY     = 32;

    // CTRL write bits.
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    // Register-lock bit positions in reglk_ctrl_i.
    localparam int LK_CTRL    = 1;  // CTRL and KEY_SEL writes
    localparam int LK_DIN_RD  = 2;  // DATA_IN reads
    localparam int LK_DIN_WR  = 3;  // DATA_IN writes
    localparam int LK_RES_RD  = 4;  // RESULT reads
    localparam int LK_KEY_WR  = 5;  // KEY writes
    localparam int LK_STAT_RD = 6;  // STATUS reads

    // Width of an index selecting one of n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_key_bank.sv
// Key storage for the cipher controller: NUM_KEYS slots of KEY_WORDS 32-bit
// words, a single-word write port, slot select mux and debug-mode masking.
module aes_key_bank #(
    parameter int NUM_KEYS  = 3,
    parameter int KEY_WORDS = 6,
    parameter int SEL_W     = 2,
    parameter int WORD_W    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_slot,
    input  logic [WORD_W-1:0]       wr_word,
    input  logic [31:0]             wr_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mask,
    output logic [32*KEY_WORDS-1:0] key
);

    logic [31:0] key_mem [NUM_KEYS][KEY_WORDS];

    // Key word write; every slot is cleared on reset.
    // NOTE: key storage is reset explicitly (unlike a plain RAM) so no secret survives a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_KEYS; k++)
                for (int w = 0; w < KEY_WORDS; w++)
                    key_mem[k][w] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_KEYS; k++)
                for (int w = 0; w < KEY_WORDS; w++)
                    if (wr_slot == SEL_W'(k) && wr_word == WORD_W'(w))
                        key_mem[k][w] <= wr_data;
        end
    end

    // Selected slot to the core, forced to zero while debug mode is active.
    always_comb begin
        key = '0;
        if (!mask) begin
            for (int k = 0; k < NUM_KEYS; k++)
                if (sel == SEL_W'(k))
                    for (int w = 0; w < KEY_WORDS; w++)
                        key[32*w +: 32] = key_mem[k][w];
        end
    end

endmodule

// File: rtl/aes_multikey_ctrl.sv
// Register-mapped control block for a block-cipher core: key slots, input and
// result buffers, start/valid handshake, register locks, debug key masking and
// post-use zeroisation. Optional busy watchdog enabled by AES_WATCHDOG_EN.
module aes_multikey_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_KEYS    = 3,
    parameter int KEY_WORDS   = 6,
    parameter int DATA_WORDS  = 4,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [63:0]              wdata_i,
    output logic [63:0]              rdata_o,
    input  logic [7:0]               reglk_ctrl_i,
    input  logic                     acct_ctrl_i,
    input  logic                     debug_mode_i,
    output logic                     core_start_o,
    output logic [32*KEY_WORDS-1:0]  core_key_o,
    output logic [32*DATA_WORDS-1:0] core_data_o,
    input  logic                     core_valid_i,
    input  logic [32*DATA_WORDS-1:0] core_out_i,
    output logic                     busy_o,
    output logic                     irq_o
);

    localparam int          SEL_W      = idx_width(NUM_KEYS);
    localparam int          WORD_W     = idx_width(KEY_WORDS);
    localparam int unsigned IDX_RESULT = IDX_DATA_IN + DATA_WORDS;
    localparam int unsigned KEY_SPAN   = NUM_KEYS * KEY_WORDS;

    state_t state, state_next;

    logic [31:0]       data_in [DATA_WORDS];
    logic [31:0]       result  [DATA_WORDS];
    logic [SEL_W-1:0]  key_sel;
    logic [SEL_W-1:0]  key_slot;
    logic [WORD_W-1:0] key_word;

    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned widx, din_idx, res_idx, key_off;

    logic access, wr, rd;
    logic hit_ctrl, hit_status, hit_ksel, hit_din, hit_res, hit_key;
    logic busy, valid, err;
    logic start_cmd, clear_cmd, timeout;
    logic latch_res, zero_din, zero_res;
    logic din_we, ksel_we, key_we;
    logic unused_bits;

    // Bus decode: only the low data word and the word index are meaningful.
    assign wdata   = wdata_i[31:0];
    assign access  = en_i & acct_ctrl_i;
    assign wr      = access & we_i;
    assign rd      = access & ~we_i;
    assign widx    = 32'(addr_i[ADDR_W-1:3]);
    assign din_idx = widx - IDX_DATA_IN;
    assign res_idx = widx - IDX_RESULT;
    assign key_off = widx - IDX_KEY;

    assign hit_ctrl   = (widx == IDX_CTRL);
    assign hit_status = (widx == IDX_STATUS);
    assign hit_ksel   = (widx == IDX_KEY_SEL);
    assign hit_din    = (widx >= IDX_DATA_IN) && (widx < IDX_RESULT);
    assign hit_res    = (widx >= IDX_RESULT) && (widx < IDX_RESULT + DATA_WORDS);
    assign hit_key    = (widx >= IDX_KEY) && (widx < IDX_KEY + KEY_SPAN);

    assign key_slot = SEL_W'(key_off / KEY_WORDS);
    assign key_word = WORD_W'(key_off % KEY_WORDS);

    assign busy  = (state == ST_LOAD) || (state == ST_BUSY);
    assign valid = (state == ST_DONE);
    assign err   = (state == ST_ERR);

    assign start_cmd = wr & hit_ctrl & ~reglk_ctrl_i[LK_CTRL] & wdata[CTRL_START];
    assign clear_cmd = wr & hit_ctrl & ~reglk_ctrl_i[LK_CTRL] & wdata[CTRL_CLEAR];

    // DATA_IN is also frozen in DONE so a valid result always coexists with a
    // zeroised input buffer.
    assign din_we  = wr & hit_din & ~reglk_ctrl_i[LK_DIN_WR] & ~busy & ~valid;
    assign ksel_we = wr & hit_ksel & ~reglk_ctrl_i[LK_CTRL] & ~busy
                     & (wdata < 32'(NUM_KEYS));
    assign key_we  = wr & hit_key & ~reglk_ctrl_i[LK_KEY_WR] & ~busy;

`ifdef AES_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Busy watchdog: counts cycles spent in BUSY, restarts outside it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wd_cnt <= '0;
        else if (state == ST_BUSY)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    assign timeout = (state == ST_BUSY) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog ERR is unreachable; TIMEOUT_CYC has no effect.
    assign timeout = 1'b0 & (TIMEOUT_CYC > 0);
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state plus buffer latch/zeroise strobes; clear beats start, debug beats valid.
    // NOTE: every signal of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        latch_res  = 1'b0;
        zero_din   = 1'b0;
        zero_res   = clear_cmd;
        case (state)
            ST_IDLE: begin
                if (start_cmd && !clear_cmd)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (debug_mode_i) begin
                    state_next = ST_IDLE;
                    zero_din   = 1'b1;
                    zero_res   = 1'b1;
                end else if (clear_cmd) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (debug_mode_i) begin
                    state_next = ST_IDLE;
                    zero_din   = 1'b1;
                    zero_res   = 1'b1;
                end else if (clear_cmd) begin
                    state_next = ST_IDLE;
                end else if (core_valid_i) begin
                    state_next = ST_DONE;
                    latch_res  = 1'b1;
                    zero_din   = 1'b1;
                end else if (timeout) begin
                    state_next = ST_ERR;
                    zero_din   = 1'b1;
                end
            end
            ST_DONE: begin
                if (clear_cmd) begin
                    state_next = ST_IDLE;
                end else if (start_cmd) begin
                    state_next = ST_LOAD;
                    zero_res   = 1'b1;
                end
            end
            ST_ERR: begin
                if (clear_cmd)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Input buffer: bus writes when idle, zeroised after use or on abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++)
                data_in[i] <= '0;
        end else if (zero_din) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++)
                data_in[i] <= '0;
        end else if (din_we) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++)
                if (din_idx == i)
                    data_in[i] <= wdata;
        end
    end

    // Result buffer: captures the core output, cleared on clear/restart/abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++)
                result[i] <= '0;
        end else if (zero_res) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++)
                result[i] <= '0;
        end else if (latch_res) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++)
                result[i] <= core_out_i[32*i +: 32];
        end
    end

    // Key slot select; out-of-range values are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            key_sel <= '0;
        else if (ksel_we)
            key_sel <= SEL_W'(wdata);
    end

    aes_key_bank #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_WORDS (KEY_WORDS),
        .SEL_W     (SEL_W),
        .WORD_W    (WORD_W)
    ) u_key_bank (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (key_we),
        .wr_slot (key_slot),
        .wr_word (key_word),
        .wr_data (wdata),
        .sel     (key_sel),
        .mask    (debug_mode_i),
        .key     (core_key_o)
    );

    // Input buffer flattened onto the core data bus.
    always_comb begin
        core_data_o = '0;
        for (int i = 0; i < DATA_WORDS; i++)
            core_data_o[32*i +: 32] = data_in[i];
    end

    // Combinational read mux with per-register read locks; keys never read back.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_status) begin
                if (!reglk_ctrl_i[LK_STAT_RD])
                    rdata = {29'b0, err, valid, busy};
            end else if (hit_ksel) begin
                rdata = 32'(key_sel);
            end else if (hit_din) begin
                if (!reglk_ctrl_i[LK_DIN_RD])
                    for (int unsigned i = 0; i < DATA_WORDS; i++)
                        if (din_idx == i)
                            rdata = data_in[i];
            end else if (hit_res) begin
                if (!reglk_ctrl_i[LK_RES_RD])
                    for (int unsigned i = 0; i < DATA_WORDS; i++)
                        if (res_idx == i)
                            rdata = result[i];
            end
        end
    end

    assign rdata_o      = {32'h0, rdata};
    assign core_start_o = (state == ST_LOAD);
    assign busy_o       = busy;
    assign irq_o        = valid | err;

    assign unused_bits = ^{wdata_i[63:32], addr_i[2:0], reglk_ctrl_i[7], reglk_ctrl_i[0]};

endmodule

// File: tb/tb_aes_multikey_ctrl.sv
// Directed bench for aes_multikey_ctrl: handshake, locks, debug masking,
// busy-write blocking, clear/restart, async reset and (when AES_WATCHDOG_EN is
// defined) the busy watchdog with TIMEOUT_CYC = 16.
module tb_aes_multikey_ctrl;

    localparam int ADDR_W = 9;

    localparam logic [191:0] KEY1 = {32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11};
    localparam logic [191:0] KEY0 = {32'h26, 32'h25, 32'h24, 32'h23, 32'h22, 32'h21};
    localparam logic [127:0] RES  = {32'hFEED0004, 32'hFEED0003, 32'hFEED0002, 32'hFEED0001};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en, we;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata, rdata;
    logic [7:0]        reglk;
    logic              acct, dbg;
    logic              core_start;
    logic [191:0]      core_key;
    logic [127:0]      core_data;
    logic              core_valid;
    logic [127:0]      core_out;
    logic              busy, irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_multikey_ctrl #(
        .NUM_KEYS    (3),
        .KEY_WORDS   (6),
        .DATA_WORDS  (4),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .reglk_ctrl_i (reglk),
        .acct_ctrl_i  (acct),
        .debug_mode_i (dbg),
        .core_start_o (core_start),
        .core_key_o   (core_key),
        .core_data_o  (core_data),
        .core_valid_i (core_valid),
        .core_out_i   (core_out),
        .busy_o       (busy),
        .irq_o        (irq)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register write; returns 1 ns after the capturing edge.
    task automatic wr(input int idx, input logic [31:0] d);
        en    = 1'b1;
        we    = 1'b1;
        addr  = ADDR_W'(idx * 8);
        wdata = 64'(d);
        tick();
        en    = 1'b0;
        we    = 1'b0;
    endtask

    // Combinational register read checked against an expected word.
    task automatic check_rd(input string tag, input int idx, input logic [31:0] exp);
        en   = 1'b1;
        we   = 1'b0;
        addr = ADDR_W'(idx * 8);
        #1;
        check(tag, 192'(rdata), 192'(exp));
        en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        reglk = '0; acct = 1'b1; dbg = 1'b0; core_valid = 1'b0; core_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  192'(busy), 192'(0));
        check("rst_irq",   192'(irq), 192'(0));
        check("rst_start", 192'(core_start), 192'(0));
        check("rst_key",   core_key, 192'(0));
        rst_n = 1'b1;
        tick();
        check_rd("rst_status", 1, 32'h0);

        // 1: key slot 1, data block, start and completion
        for (int w = 0; w < 6; w++) wr(38 + w, 32'h11 + w);
        wr(2, 32'h1);
        wr(4, 32'hA); wr(5, 32'hB); wr(6, 32'hC); wr(7, 32'hD);
        check("t1_data", 192'(core_data), 192'({32'hD, 32'hC, 32'hB, 32'hA}));
        check("t1_nostart", 192'(core_start), 192'(0));
        wr(0, 32'h1);
        check("t1_start", 192'(core_start), 192'(1));
        check("t1_key", core_key, KEY1);
        tick();
        check("t1_pulse_once", 192'(core_start), 192'(0));
        check("t1_busy", 192'(busy), 192'(1));
        core_out = RES; core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
        for (int i = 0; i < 4; i++) check_rd("t1_result", 8 + i, 32'hFEED0001 + i);
        check_rd("t1_status", 1, 32'h2);
        check_rd("t1_din_zero", 4, 32'h0);
        check("t1_irq", 192'(irq), 192'(1));
        wr(2, 32'h3);
        check("t1_ksel_oor", core_key, KEY1);
        wr(0, 32'h1);
        check_rd("t1_restart_status", 1, 32'h1);
        check_rd("t1_restart_result", 8, 32'h0);
        wr(0, 32'h2);
        check_rd("t1_clear_abort", 1, 32'h0);
        wr(0, 32'h1);
        tick();
        core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
        check_rd("t4_done", 1, 32'h2);
        wr(0, 32'h3);
        check_rd("t4_clear_status", 1, 32'h0);
        check_rd("t4_clear_result", 8, 32'h0);
        check("t4_clear_nostart", 192'(core_start), 192'(0));

        // 2: locks
        reglk = 8'h28;
        wr(4, 32'h55);
        wr(32, 32'h77);
        wr(2, 32'h0);
        check_rd("t2_din_wrlk", 4, 32'h0);
        check("t2_key_wrlk", core_key, 192'(0));
        check_rd("t2_key_rd", 38, 32'h0);
        reglk = 8'h00;
        wr(5, 32'h42);
        check_rd("t2_din_rd", 5, 32'h42);
        reglk = 8'h04;
        check_rd("t2_din_rdlk", 5, 32'h0);
        reglk = 8'h02;
        wr(2, 32'h1);
        check("t2_ksel_lk", core_key, 192'(0));
        reglk = 8'h00;
        acct = 1'b0;
        wr(6, 32'hEE);
        acct = 1'b1;
        check_rd("t2_acct", 6, 32'h0);

        // 3: debug masking and abort; 4: busy write blocking
        for (int w = 0; w < 6; w++) wr(32 + w, 32'h21 + w);
        check("t3_key0", core_key, KEY0);
        dbg = 1'b1;
        #1;
        check("t3_dbg_mask", core_key, 192'(0));
        dbg = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) wr(4 + i, 32'(i + 1));
        wr(0, 32'h1);
        tick();
        wr(6, 32'h99);
        check_rd("t4_din_busy", 6, 32'h3);
        wr(2, 32'h1);
        dbg = 1'b1;
        tick();
        dbg = 1'b0;
        check("t3_dbg_abort", 192'(busy), 192'(0));
        check_rd("t3_dbg_din", 4, 32'h0);
        check_rd("t3_dbg_res", 8, 32'h0);
        core_out = RES; core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
        check_rd("t3_late_status", 1, 32'h0);
        check_rd("t3_late_res", 8, 32'h0);
        check("t4_ksel_busy", core_key, KEY0);

        // 5: asynchronous reset mid-BUSY
        wr(4, 32'h5A);
        wr(0, 32'h1);
        tick();
        check("t5_pre_busy", 192'(busy), 192'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 192'(busy), 192'(0));
        check("t5_key", core_key, 192'(0));
        check("t5_data", 192'(core_data), 192'(0));
        check("t5_irq", 192'(irq), 192'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check_rd("t5_status", 1, 32'h0);

        // 6: watchdog
`ifdef AES_WATCHDOG_EN
        wr(4, 32'h77);
        wr(0, 32'h1);
        repeat (16) tick();
        check("t6_still_busy", 192'(busy), 192'(1));
        tick();
        check("t6_err_busy", 192'(busy), 192'(0));
        check("t6_err_irq", 192'(irq), 192'(1));
        check_rd("t6_err_status", 1, 32'h4);
        check_rd("t6_err_din", 4, 32'h0);
        wr(0, 32'h2);
        check("t6_clear_irq", 192'(irq), 192'(0));
        check_rd("t6_clear_status", 1, 32'h0);
`else
        wr(0, 32'h1);
        repeat (40) tick();
        check_rd("t6_no_wd_status", 1, 32'h1);
        wr(0, 32'h2);
        check("t6_no_wd_clear", 192'(busy), 192'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
